// File: rtl/ysyx_22050133_rw_arbiter.sv
// Merges the fetch (read-only) and LSU (read/write) request ports onto the AXI master's rw_* interface.
// Optional ARB_ROUND_ROBIN_EN: alternate priority between ports instead of fixed LSU priority.
module ysyx_22050133_rw_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic [7:0]            if_len,
  input  logic [2:0]            if_size,
  output logic                  if_rdata_valid,
  input  logic                  if_rdata_ready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_rlast,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic                  ls_we,
  input  logic [7:0]            ls_len,
  input  logic [2:0]            ls_size,
  input  logic                  ls_wdata_valid,
  output logic                  ls_wdata_ready,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_rdata_valid,
  input  logic                  ls_rdata_ready,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  ls_rlast,
  output logic                  m_addr_valid,
  input  logic                  m_addr_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_we,
  output logic [7:0]            m_len,
  output logic [2:0]            m_size,
  output logic [1:0]            m_burst,
  output logic                  m_wdata_valid,
  input  logic                  m_wdata_ready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_rdata_valid,
  output logic                  m_rdata_ready,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  typedef enum logic [2:0] {IDLE, REQ, RDATA, WDATA, WRESP} state_t;

  state_t                  state, state_nxt;
  logic                    gnt_ls, gnt_if;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q, size_pad, cnt;
  logic [2:0]              size_q;
  logic                    we_q;
  logic                    ls_first, sel_ls, sel_if, accept;
  logic                    r_hs, w_hs, last;

`ifdef ARB_ROUND_ROBIN_EN
  // prio_ls=1 means LSU wins a tie; flips to favour whichever port lost last time.
  logic prio_ls;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        prio_ls <= 1'b1;
    else if (accept) prio_ls <= sel_if;
  end
  assign ls_first = prio_ls;
`else
  assign ls_first = 1'b1;
`endif

  assign sel_ls = ls_req_valid & (~if_req_valid | ls_first);
  assign sel_if = if_req_valid & ~sel_ls;
  assign accept = (state == IDLE) & (sel_ls | sel_if);
  assign last   = (cnt == len_q);
  assign r_hs   = (state == RDATA) & m_rdata_valid & m_rdata_ready;
  assign w_hs   = (state == WDATA) & ls_wdata_valid & m_wdata_ready;
  assign size_pad = {5'd0, size_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (m_addr_ready) state_nxt = we_q ? WDATA : RDATA;
      RDATA:   if (r_hs && last) state_nxt = IDLE;
      WDATA:   if (w_hs && last) state_nxt = WRESP;
      // master re-raises addr_ready only after the write response completes
      WRESP:   if (m_addr_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
      we_q   <= 1'b0;
      gnt_ls <= 1'b0;
      gnt_if <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      addr_q <= sel_ls ? ls_addr : if_addr;
      len_q  <= sel_ls ? ls_len  : if_len;
      size_q <= sel_ls ? ls_size : if_size;
      we_q   <= sel_ls & ls_we;
      gnt_ls <= sel_ls;
      gnt_if <= sel_if;
      cnt    <= '0;
    end else if ((r_hs || w_hs) && !last) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign if_req_ready   = (state == IDLE) & sel_if;
  assign ls_req_ready   = (state == IDLE) & sel_ls;

  assign m_addr_valid   = (state == REQ);
  assign m_addr         = addr_q;
  assign m_len          = len_q;
  assign m_size         = size_pad[2:0];
  assign m_we           = we_q;
  assign m_burst        = 2'b01;

  assign m_rdata_ready  = (state == RDATA) & (gnt_ls ? ls_rdata_ready : if_rdata_ready);
  assign if_rdata_valid = (state == RDATA) & gnt_if & m_rdata_valid;
  assign ls_rdata_valid = (state == RDATA) & gnt_ls & m_rdata_valid;
  assign if_rdata       = m_rdata;
  assign ls_rdata       = m_rdata;
  assign if_rlast       = (state == RDATA) & gnt_if & last;
  assign ls_rlast       = (state == RDATA) & gnt_ls & last;

  assign m_wdata_valid  = (state == WDATA) & ls_wdata_valid;
  assign ls_wdata_ready = (state == WDATA) & m_wdata_ready;
  assign m_wdata        = ls_wdata;

endmodule

// File: tb/tb_ysyx_22050133_rw_arbiter.sv
// Directed + randomized bench for ysyx_22050133_rw_arbiter; plays both clients and the AXI master.
module tb_ysyx_22050133_rw_arbiter;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  l;
    logic [2:0]  s;
    logic        we;
  } req_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req_valid = 0, if_req_ready, if_rdata_valid, if_rdata_ready = 0, if_rlast;
  logic [31:0] if_addr = 0, ls_addr = 0, m_addr;
  logic [7:0]  if_len = 0, ls_len = 0, m_len;
  logic [2:0]  if_size = 0, ls_size = 0, m_size;
  logic [63:0] if_rdata, ls_rdata, ls_wdata = 0, m_wdata, m_rdata = 0;
  logic        ls_req_valid = 0, ls_req_ready, ls_we = 0, ls_wdata_valid = 0, ls_wdata_ready;
  logic        ls_rdata_valid, ls_rdata_ready = 0, ls_rlast;
  logic        m_addr_valid, m_addr_ready = 0, m_we, m_wdata_valid, m_wdata_ready = 0;
  logic        m_rdata_valid = 0, m_rdata_ready;
  logic [1:0]  m_burst;

  int errors = 0, checks = 0;
  bit prio_ls = 1'b1;

  ysyx_22050133_rw_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_len(if_len), .if_size(if_size), .if_rdata_valid(if_rdata_valid),
    .if_rdata_ready(if_rdata_ready), .if_rdata(if_rdata), .if_rlast(if_rlast),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_len(ls_len), .ls_size(ls_size), .ls_wdata_valid(ls_wdata_valid),
    .ls_wdata_ready(ls_wdata_ready), .ls_wdata(ls_wdata), .ls_rdata_valid(ls_rdata_valid),
    .ls_rdata_ready(ls_rdata_ready), .ls_rdata(ls_rdata), .ls_rlast(ls_rlast),
    .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready), .m_addr(m_addr),
    .m_we(m_we), .m_len(m_len), .m_size(m_size), .m_burst(m_burst),
    .m_wdata_valid(m_wdata_valid), .m_wdata_ready(m_wdata_ready), .m_wdata(m_wdata),
    .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: LSU wins ties unless round-robin hands the tie to the port that lost last.
  function automatic bit pick_ls(input bit iv, input bit lv);
`ifdef ARB_ROUND_ROBIN_EN
    return lv && (!iv || prio_ls);
`else
    return lv;
`endif
  endfunction

  // Entered one step after the acceptance edge; returns one step after the edge that ends the
  // transaction (or, with abort_at>=0, after that many read beats while still mid-burst).
  task automatic serve(input bit is_ls, input req_t r, input int stall, input logic [63:0] dbase,
                       input bit toggle, input int abort_at);
    int beat, cyc, k;
    bit rr, hs;
    logic [63:0] d;
    for (int c = 0; c <= stall; c++) begin
      m_addr_ready = (c == stall);
      ls_wdata_valid = 1'b1; m_wdata_ready = 1'b1;
      #1;
      chk("m_addr_valid", m_addr_valid, 1);
      chk("m_addr", m_addr, r.a);
      chk("m_len", m_len, r.l);
      chk("m_size", m_size, r.s);
      chk("m_we", m_we, is_ls & r.we);
      chk("m_burst", m_burst, 2'b01);
      chk("req_ready busy", {if_req_ready, ls_req_ready}, 0);
      chk("wdata blocked in REQ", {m_wdata_valid, ls_wdata_ready}, 0);
      @(posedge clk); #1;
    end
    m_addr_ready = 0; ls_wdata_valid = 0; m_wdata_ready = 0;
    beat = 0; cyc = 0;
    if (!(is_ls && r.we)) begin
      while (beat <= int'(r.l) && beat != abort_at) begin
        if (cyc > 4000) begin chk("read timeout beats", beat, r.l + 1); break; end
        m_rdata_valid = toggle ? 1'b1 : ($urandom_range(3) != 0);
        d = dbase + 64'(beat);
        m_rdata = d;
        rr = toggle ? (cyc % 2 == 0) : 1'($urandom_range(1));
        if_rdata_ready = is_ls ? 1'($urandom_range(1)) : rr;
        ls_rdata_ready = is_ls ? rr : 1'($urandom_range(1));
        #1;
        chk("m_rdata_ready", m_rdata_ready, rr);
        chk("rdata_valid", is_ls ? ls_rdata_valid : if_rdata_valid, m_rdata_valid);
        chk("rdata_valid other", is_ls ? if_rdata_valid : ls_rdata_valid, 0);
        chk("rdata", is_ls ? ls_rdata : if_rdata, d);
        chk("rlast", is_ls ? ls_rlast : if_rlast, beat == int'(r.l));
        chk("rlast other", is_ls ? if_rlast : ls_rlast, 0);
        chk("req_ready in RDATA", {if_req_ready, ls_req_ready}, 0);
        hs = m_rdata_valid && rr;
        @(posedge clk); #1;
        if (hs) beat++;
        cyc++;
      end
      if (abort_at < 0) begin
        m_rdata_valid = 0; if_rdata_ready = 0; ls_rdata_ready = 0;
      end
    end else begin
      while (beat <= int'(r.l)) begin
        if (cyc > 4000) begin chk("write timeout beats", beat, r.l + 1); break; end
        ls_wdata_valid = ($urandom_range(2) != 0);
        d = dbase + 64'(beat) + 64'd1;
        ls_wdata = d;
        m_wdata_ready = ($urandom_range(3) != 0);
        #1;
        chk("m_wdata_valid", m_wdata_valid, ls_wdata_valid);
        chk("m_wdata", m_wdata, d);
        chk("ls_wdata_ready", ls_wdata_ready, m_wdata_ready);
        chk("m_rdata_ready in WDATA", m_rdata_ready, 0);
        hs = ls_wdata_valid && m_wdata_ready;
        @(posedge clk); #1;
        if (hs) beat++;
        cyc++;
      end
      ls_wdata_valid = 1; m_wdata_ready = 1;
      k = $urandom_range(3);
      for (int c = 0; c <= k; c++) begin
        m_addr_ready = (c == k);
        #1;
        chk("wresp m_addr_valid", m_addr_valid, 0);
        chk("wresp no extra beat", {m_wdata_valid, ls_wdata_ready}, 0);
        chk("wresp m_addr held", m_addr, r.a);
        chk("wresp m_len held", m_len, r.l);
        chk("wresp req_ready", {if_req_ready, ls_req_ready}, 0);
        @(posedge clk); #1;
      end
      m_addr_ready = 0; ls_wdata_valid = 0; m_wdata_ready = 0;
    end
  endtask

  // Present requests from one or both ports and serve every granted transaction in model order.
  task automatic arb(input bit iv, input bit lv, input req_t ir, input req_t lr, input int stall,
                     input logic [63:0] dbase, input bit toggle, input int abort_at);
    bit wl;
    if_req_valid = iv; if_addr = ir.a; if_len = ir.l; if_size = ir.s;
    ls_req_valid = lv; ls_addr = lr.a; ls_len = lr.l; ls_size = lr.s; ls_we = lr.we;
    #1;
    wl = pick_ls(iv, lv);
    chk("if_req_ready", if_req_ready, iv && !wl);
    chk("ls_req_ready", ls_req_ready, wl);
    @(posedge clk); #1;
    prio_ls = !wl;
    if (wl) ls_req_valid = 0; else if_req_valid = 0;
    serve(wl, wl ? lr : ir, stall, dbase, toggle, abort_at);
    if (iv && lv) begin
      #1;
      chk("stalled port granted", wl ? if_req_ready : ls_req_ready, 1);
      chk("other ready after", wl ? ls_req_ready : if_req_ready, 0);
      @(posedge clk); #1;
      prio_ls = wl;
      if (wl) if_req_valid = 0; else ls_req_valid = 0;
      serve(!wl, wl ? ir : lr, 0, ~dbase, toggle, -1);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " m_addr_valid"}, m_addr_valid, 0);
    chk({tag, " m_addr"}, m_addr, 0);
    chk({tag, " m_len"}, m_len, 0);
    chk({tag, " m_size"}, m_size, 0);
    chk({tag, " m_we"}, m_we, 0);
    chk({tag, " rdata_valid"}, {if_rdata_valid, ls_rdata_valid}, 0);
    chk({tag, " rlast"}, {if_rlast, ls_rlast}, 0);
    chk({tag, " m_rdata_ready"}, m_rdata_ready, 0);
    chk({tag, " wdata hs"}, {m_wdata_valid, ls_wdata_ready}, 0);
  endtask

  initial begin
    req_t ri, rl;
    bit iv, lv;
    repeat (2) @(posedge clk);
    #2;
    chk_idle_zero("reset");
    chk("reset req_ready", {if_req_ready, ls_req_ready}, 0);
    @(posedge clk); #1;
    rst = 1;

    // fetch-only single beat
    ri = req_t'{32'h8000_0000, 8'd0, 3'd3, 1'b0};
    rl = req_t'{32'h0, 8'd0, 3'd0, 1'b0};
    arb(1, 0, ri, rl, 0, 64'h1122334455667788, 0, -1);
    // simultaneous fetch + LSU read
    rl = req_t'{32'h8000_1000, 8'd0, 3'd3, 1'b0};
    arb(1, 1, ri, rl, 0, 64'hDEAD_0000_0000_0000, 0, -1);
    // LSU goes last, then a tie
    arb(0, 1, ri, rl, 0, 64'h100, 0, -1);
    arb(1, 1, ri, rl, 0, 64'h200, 0, -1);
    // LSU write len=3, beats 0x1..0x4
    rl = req_t'{32'h8000_2000, 8'd3, 3'd3, 1'b1};
    arb(0, 1, ri, rl, 0, 64'h0, 0, -1);
    // fetch burst len=7 with toggling ready
    ri = req_t'{32'h8000_0040, 8'd7, 3'd3, 1'b0};
    arb(1, 0, ri, rl, 0, 64'h5000, 1, -1);
    // request backpressure with both ports pending
    rl = req_t'{32'h8000_3000, 8'd1, 3'd2, 1'b0};
    arb(1, 1, ri, rl, 5, 64'h7000, 0, -1);
    // maximal burst
    ri = req_t'{32'h8000_4000, 8'd255, 3'd3, 1'b0};
    arb(1, 0, ri, rl, 1, 64'h9000, 0, -1);

    // reset after 2 of 4 beats
    ri = req_t'{32'h8000_5000, 8'd3, 3'd3, 1'b0};
    arb(1, 0, ri, rl, 0, 64'hA000, 0, 2);
    m_rdata_valid = 1; if_rdata_ready = 1;
    #2;
    rst = 0;
    #1;
    chk_idle_zero("mid-reset");
    @(posedge clk); #1;
    m_rdata_valid = 0; if_rdata_ready = 0;
    rst = 1;
    prio_ls = 1'b1;
    arb(1, 0, ri, rl, 0, 64'hB000, 0, -1);

    for (int n = 0; n < 40; n++) begin
      iv = 1'($urandom_range(1));
      lv = iv ? 1'($urandom_range(1)) : 1'b1;
      ri = req_t'{$urandom, 8'($urandom_range(7)), 3'($urandom_range(7)), 1'b0};
      rl = req_t'{$urandom, 8'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom_range(1))};
      arb(iv, lv, ri, rl, $urandom_range(3), {$urandom, $urandom}, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
